// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: DATA register feeds a byte FIFO, STATUS reports {overflow, full, busy}.
// Define UART_TX_PARITY_EN to append an even-parity bit after the 8 data bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        addr,
  output logic [15:0] out,
  output logic        tx
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             r_state, w_state_n;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [BAUD_W-1:0]  r_baud, w_baud_n;
  logic [2:0]         r_bit, w_bit_n;
  logic [7:0]         r_data, w_data_n;
  logic               r_tx, w_tx_n;
  logic               r_overflow;
  logic               w_empty, w_full, w_pop, w_push, w_wr_data, w_drop, w_ovf_clr;
  logic               w_baud_end, w_busy;
  logic               w_unused_in;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_wr_data   = load & ~addr;
  assign w_push      = w_wr_data & (~w_full | w_pop);
  assign w_drop      = w_wr_data & w_full & ~w_pop;
  assign w_ovf_clr   = load & addr & in[2];
  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_busy      = (r_state != IDLE) | ~w_empty;
  assign w_unused_in = ^in[15:8];

  assign out = addr ? {13'b0, r_overflow, w_full, w_busy} : 16'h0000;
  assign tx  = r_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_tx    <= w_tx_n;
    end
  end

  always_ff @(posedge clk) begin
    r_data <= w_data_n;
  end

  // Next-state logic; tx is registered from the next-state values so it changes with the state.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_data_n  = r_data;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_data_n  = r_mem[r_rd_ptr];
          w_state_n = START;
          w_baud_n  = '0;
          w_bit_n   = '0;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_state_n = DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = PARITY;
`else
            w_state_n = STOP;
`endif
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_baud_end) begin
          w_state_n = STOP;
          w_baud_n  = '0;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          w_bit_n  = '0;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_data_n  = r_mem[r_rd_ptr];
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase

    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_data_n[w_bit_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_n = ^w_data_n;
`endif
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in[7:0];
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset, load, addr, tx;
  logic [15:0] din, dout;
  int          n_checks = 0;
  int          n_fail   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .addr(addr), .out(dout), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < CPB)          return 1'b0;
    else if (k < 9 * CPB) return b[(k - CPB) / CPB];
`ifdef UART_TX_PARITY_EN
    else if (k < 10 * CPB) return ^b;
`endif
    else                  return 1'b1;
  endfunction

  task automatic chk_status(input string tag, input logic [15:0] exp);
    addr = 1'b1;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_tx(input string tag, input logic exp);
    check(tag, {15'b0, tx}, {15'b0, exp});
  endtask

  // Called at the negedge holding frame cycle 0; returns at the negedge just after the frame.
  task automatic frame(input logic [7:0] b, input string tag);
    for (int k = 0; k < FRAME; k++) begin
      chk_tx($sformatf("%s k%0d", tag, k), exp_tx(b, k));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b0; addr = 1'b1; din = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write(input logic a, input logic [15:0] v);
    load = 1'b1; addr = a; din = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [7:0] ovf_bytes [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
  int lows;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; addr = 1'b0; din = 16'h0000;
    do_reset();
    chk_tx("reset_tx", 1'b1);
    chk_status("reset_status", 16'h0000);
    addr = 1'b0; #1;
    check("reset_data_read", dout, 16'h0000);

    // Single byte: tx still high one cycle after the write, low the next.
    write(1'b0, 16'h00A5);
    chk_tx("single_latency", 1'b1);
    chk_status("single_busy", 16'h0001);
    @(negedge clk);
    frame(8'hA5, "single");
    chk_tx("single_idle_tx", 1'b1);
    chk_status("single_done", 16'h0000);

    // Back-to-back: upper byte of the write is ignored; no idle gap between frames.
    load = 1'b1; addr = 1'b0; din = 16'hAB55;
    @(negedge clk);
    din = 16'h00FF;
    @(negedge clk);
    load = 1'b0;
    frame(8'h55, "b2b_first");
    frame(8'hFF, "b2b_second");
    chk_tx("b2b_idle_tx", 1'b1);
    chk_status("b2b_done", 16'h0000);

    // Overflow: six writes while idle, sixth dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; addr = 1'b0; din = {8'h00, ovf_bytes[i]};
      @(negedge clk);
    end
    load = 1'b0;
    chk_status("ovf_status", 16'h0007);
    addr = 1'b0; #1;
    check("ovf_data_read", dout, 16'h0000);
    write(1'b1, 16'h0004);
    chk_status("ovf_cleared", 16'h0003);
    repeat (FRAME - 6) @(negedge clk);
    chk_status("full_before_pop", 16'h0003);
    chk_tx("first_stop_tail", 1'b1);
    // Push into full FIFO on the same cycle as the pop.
    write(1'b0, 16'h00C3);
    chk_status("push_with_pop", 16'h0003);
    for (int i = 1; i < 5; i++) frame(ovf_bytes[i], $sformatf("ovf_q%0d", i));
    frame(8'hC3, "ovf_late");
    chk_tx("ovf_idle_tx", 1'b1);
    chk_status("ovf_drained", 16'h0000);

    // Reset during the last cycle of DATA bit 3 of 8'h0F, with a coincident write.
    do_reset();
    load = 1'b1; addr = 1'b0; din = 16'h000F;
    @(negedge clk);
    din = 16'h0011;
    @(negedge clk);
    din = 16'h0022;
    @(negedge clk);
    load = 1'b0;
    chk_status("rst_queued", 16'h0001);
    repeat (18) @(negedge clk);
    chk_tx("rst_bit3", 1'b1);
    reset = 1'b1; load = 1'b1; addr = 1'b0; din = 16'h0033;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    chk_tx("rst_abort_tx", 1'b1);
    chk_status("rst_status", 16'h0000);
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_no_frames", 16'(lows), 16'h0000);
    chk_status("rst_status_late", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (115200 baud at 50 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of byte entries in the transmit FIFO; legal values are powers of two, 2 and above.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in, input, 16 bits: CPU write data (outM).
REQ-006 SHALL have port load, input, 1 bit: write strobe (decoder select AND writeM).
REQ-007 SHALL have port addr, input, 1 bit: register select; 0 = DATA, 1 = STATUS.
REQ-008 SHALL have port out, output, 16 bits: read data, combinational from addr.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-010 SHALL push in[7:0] into the FIFO on a cycle with load=1, addr=0 and FIFO not full; in[15:8] ignored.
REQ-011 SHALL drop a DATA write when the FIFO is full and no pop occurs that cycle, and SHALL set the sticky overflow flag.
REQ-012 SHALL accept a push into a full FIFO when a pop occurs in the same cycle; no overflow is flagged.
REQ-013 SHALL clear overflow on load=1, addr=1 with in[2]=1; other STATUS write bits are ignored.
REQ-014 SHALL drive out = {13'b0, overflow, full, busy} when addr=1, and 16'h0000 when addr=0.
REQ-015 SHALL define busy = (state != IDLE) OR (FIFO not empty); full = (count == FIFO_DEPTH).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with FIFO non-empty, SHALL pop the head into the shift register and enter START on the next edge; tx goes low the cycle after the pop.
REQ-018 SHALL hold each bit for exactly CLKS_PER_BIT cycles: START (tx=0), DATA (8 bits, LSB first), optional PARITY, STOP (tx=1).
REQ-019 At the end of STOP with FIFO non-empty, SHALL pop and enter START directly, with no idle cycle between frames.
REQ-020 At the end of STOP with FIFO empty, SHALL enter IDLE.
REQ-021 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH and count in 0..FIFO_DEPTH.
REQ-022 SHALL drive tx from a register (glitch-free); latency from DATA write (into empty FIFO, IDLE) to falling start-bit edge is 2 cycles.

Reset
REQ-023 On reset=1 at a clk edge, SHALL set state=IDLE, tx=1, FIFO empty (pointers and count 0), overflow=0, and bit and baud counters to 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately (tx=1 the next cycle) and discard all FIFO contents.
REQ-025 A write coincident with reset SHALL be ignored.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL insert an even-parity bit (XOR of the 8 data bits) after DATA: 11-bit frame, 11*CLKS_PER_BIT cycles.
REQ-027 With UART_TX_PARITY_EN undefined, PARITY state and logic SHALL be absent: 10-bit frame, 10*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte: reset, write DATA 16'h00A5 -> tx low 2 cycles later, bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high; total 40 cycles (44 with parity, parity bit=0); busy falls after stop.
REQ-029 Back-to-back: write 8'h55 and 8'hFF on consecutive cycles -> second start bit begins immediately after first stop bit ends; no extra idle cycle.
REQ-030 Overflow: while IDLE, write 6 bytes on consecutive cycles -> 5 accepted (1 popped, 4 queued); 6th dropped; STATUS reads 16'h0007; after writing STATUS 16'h0004 it reads 16'h0003.
REQ-031 Reset mid-frame: assert reset during DATA bit 3 of 8'h0F with 2 bytes queued -> tx=1 next cycle; STATUS=16'h0000; no further frames.
REQ-032 Readback: addr=0 -> out=16'h0000 at all times; STATUS bit 1 (full) set exactly when 4 bytes are queued.
